alu_seq: RTL
============

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: cmd_valid  input  1  command present.
REQ-004 SHALL have port: cmd_ready  output  1  block accepts command this cycle.
REQ-005 SHALL have port: cmd_load  input  1  1 = load accumulator with cmd_data, 0 = ALU operation.
REQ-006 SHALL have port: cmd_op  input  3  ALU operation code, passed through unmodified.
REQ-007 SHALL have port: cmd_data  input  4  immediate operand (ALU B side or load value).
REQ-008 SHALL have port: cmd_cin  input  1  carry-in for the operation.
REQ-009 SHALL have port: cmd_chain  input  1  use stored carry as carry-in (macro-dependent).
REQ-010 SHALL have ports: alu_a, alu_b  output  4 each; alu_op  output  3; alu_cin  output  1. These drive the external ALU.
REQ-011 SHALL have ports: alu_r  input  4; alu_zero, alu_carry, alu_sign  input  1 each. These are the external ALU results.
REQ-012 SHALL have ports: acc  output  4; flag_z, flag_c, flag_s  output  1 each. All are registered.
REQ-013 SHALL have port: res_valid  output  1  one-cycle pulse, acc/flags just updated.

Function
REQ-014 SHALL implement FSM states IDLE and EXEC; cmd_ready = 1 only in IDLE.
REQ-015 SHALL, on cmd_valid & cmd_ready at edge t0, register cmd_load/op/data/cin/chain and enter EXEC.
REQ-016 SHALL, in EXEC, drive alu_a = acc, alu_b = registered data, alu_op = registered op, alu_cin per REQ-024/025, all from registers (no combinational path from cmd_* to alu_*).
REQ-017 SHALL, at edge t1 (first edge in EXEC), for an ALU command: acc <= alu_r, flag_z <= alu_zero, flag_c <= alu_carry, flag_s <= alu_sign; return to IDLE.
REQ-018 SHALL, at edge t1 for a load command: acc <= data, flag_z <= (data == 0), flag_s <= data[3], flag_c <= 0; ALU inputs ignored.
REQ-019 SHALL assert res_valid for exactly the cycle t1..t2; no res_valid otherwise.
REQ-020 SHALL have a latency of 2 edges from acceptance to updated acc, with a throughput of 1 command per 2 cycles; res_valid and cmd_ready may both be high in the same cycle; a back-to-back command accepted in that cycle uses the updated acc.
REQ-021 SHALL hold acc, flags and alu_* outputs stable in IDLE; cmd_valid while in EXEC is not accepted and must be held by the source.
REQ-022 SHALL perform all arithmetic at 4 bits; no sign or width extension.

Reset
REQ-023 SHALL, on reset asserted (any time, including mid-EXEC), immediately set state = IDLE, acc = 0, flag_z = 0, flag_c = 0, flag_s = 0, res_valid = 0, alu_a = alu_b = 0, alu_op = 0, alu_cin = 0; the in-flight command is dropped without res_valid; cmd_ready = 1 from the first edge after deassertion.

Configuration
REQ-024 SHALL, with ALU_SEQ_CARRY_CHAIN_EN defined, drive alu_cin = flag_c when registered chain = 1, otherwise registered cin.
REQ-025 SHALL, without ALU_SEQ_CARRY_CHAIN_EN, drive alu_cin = registered cin always; cmd_chain is ignored (port retained).

Structure
REQ-026 SHALL place the data width constant (4), the op width constant (3) and the state encodings (IDLE = 0, EXEC = 1) in shared package alu_seq_pkg.
REQ-027 SHALL contain sub-module flag_reg: a 3-bit flag register with asynchronous reset and load enable, holding z/c/s; the ALU itself stays external.

Verification
REQ-028 SHALL cover: after reset, load cmd_data = 4'h5 -> at t1, acc = 5, z = 0, c = 0, s = 0, res_valid high for 1 cycle.
REQ-029 SHALL cover: from acc = 5, op = 3'b010, data = 4'h3 -> during EXEC alu_a = 5, alu_b = 3, alu_op = 010; bench returns r = 4'h8, carry = 0, sign = 1, zero = 0 -> acc = 8, s = 1, z = 0.
REQ-030 SHALL cover: load 4'h0 -> z = 1, s = 0, c = 0; then load 4'h9 -> z = 0, s = 1.
REQ-031 SHALL cover: cmd_valid held high continuously -> cmd_ready toggles 1,0,1,0; each accepted command produces exactly one res_valid; the second command sees the first command's acc on alu_a.
REQ-032 SHALL cover: with ALU_SEQ_CARRY_CHAIN_EN defined, flag_c = 1, chain = 1, cin = 0 -> alu_cin = 1; the same stimulus without the macro -> alu_cin = 0.
REQ-033 SHALL cover: reset asserted mid-EXEC -> acc = 0, no res_valid, cmd_ready = 1 after release.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared widths, flag bit positions and FSM state encoding for alu_seq.
// Revision 1.0
`default_nettype none

package alu_seq_pkg;

  localparam int DATA_W = 4;
  localparam int OP_W   = 3;
  localparam int FLAG_W = 3;

  // Bit positions inside the packed {z, c, s} flag vector
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_S = 0;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  function automatic logic [FLAG_W-1:0] pack_flags(input logic z, input logic c, input logic s);
    return {z, c, s};
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_seq_flag_reg.sv
// flag_reg: 3-bit {z, c, s} flag register with asynchronous reset and load enable.
// Revision 1.0
`default_nettype none

module flag_reg
  import alu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [FLAG_W-1:0] d,
  output logic [FLAG_W-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (load_en) begin
      q <= d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// alu_seq: two-state sequencer driving an external 4-bit ALU into an accumulator with flags.
// Optional macro ALU_SEQ_CARRY_CHAIN_EN: stored carry may replace carry-in when chain is set.
`default_nettype none

module alu_seq
  import alu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_load,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              cmd_cin,
  input  logic              cmd_chain,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  output logic              alu_cin,
  input  logic [DATA_W-1:0] alu_r,
  input  logic              alu_zero,
  input  logic              alu_carry,
  input  logic              alu_sign,
  output logic [DATA_W-1:0] acc,
  output logic              flag_z,
  output logic              flag_c,
  output logic              flag_s,
  output logic              res_valid
);

  state_t state;
  state_t next_state;

  logic              accept;
  logic              exec;
  logic              load_q;
  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] data_q;
  logic              cin_q;
  logic              chain_q;
  logic [FLAG_W-1:0] flags_d;
  logic [FLAG_W-1:0] flags_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    cmd_ready  = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          next_state = EXEC;
        end
      end
      EXEC: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign accept = cmd_valid & cmd_ready;
  assign exec   = (state == EXEC);

  // Command fields are captured once and held, so the ALU sees only registered values
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_q  <= 1'b0;
      op_q    <= '0;
      data_q  <= '0;
      cin_q   <= 1'b0;
      chain_q <= 1'b0;
    end else if (accept) begin
      load_q  <= cmd_load;
      op_q    <= cmd_op;
      data_q  <= cmd_data;
      cin_q   <= cmd_cin;
      chain_q <= cmd_chain;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (exec) begin
      acc <= load_q ? data_q : alu_r;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_valid <= 1'b0;
    end else begin
      res_valid <= exec;
    end
  end

  always_comb begin
    flags_d = pack_flags(alu_zero, alu_carry, alu_sign);
    if (load_q) begin
      flags_d = pack_flags(data_q == '0, 1'b0, data_q[DATA_W-1]);
    end
  end

  flag_reg u_flag_reg (
    .clk     (clk),
    .reset   (reset),
    .load_en (exec),
    .d       (flags_d),
    .q       (flags_q)
  );

  assign flag_z = flags_q[FLAG_Z];
  assign flag_c = flags_q[FLAG_C];
  assign flag_s = flags_q[FLAG_S];

  assign alu_a  = acc;
  assign alu_b  = data_q;
  assign alu_op = op_q;

`ifdef ALU_SEQ_CARRY_CHAIN_EN
  assign alu_cin = chain_q ? flags_q[FLAG_C] : cin_q;
`else
  logic unused_chain;
  assign unused_chain = chain_q;
  assign alu_cin      = cin_q;
`endif

endmodule

`default_nettype wire
